timer_bank: RTL and testbench

// - N-channel programmable down-counting divider for the sound-chip frequency and envelope timers.
// - Replaces separate single-channel fixed-period and variable-period timers with one bank that adds:
//   - a shared prescaler,
//   - per-channel period write and restart,
//   - periodic/one-shot mode, enable gating and active status.
// - Each channel emits a one-cycle tick pulse every PERIOD prescaled steps.

---
 rtl/timer_bank.sv | 97 +++++++++
 tb/tb_timer_bank.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bank.sv
// timer_bank: bank of independent programmable down-counting dividers that
// share one prescaler. Each channel emits a one-cycle tick every PERIOD
// prescaled steps (period 0 means 2^WIDTH). Channels can be periodic or
// one-shot, are gated by a per-channel enable and report when they are running.
//
// Ports
//   clk        system clock, all state changes on posedge
//   rst        synchronous reset, active-high
//   wr_en      channel configuration write strobe
//   wr_chan    target channel of the write (out-of-range writes are ignored)
//   wr_period  period in steps (0 = 2^WIDTH)
//   wr_oneshot 1 = one-shot, 0 = periodic
//   wr_start   with wr_en: load the counter and mark the channel active
//   en         per-channel count enable
//   tick       registered one-cycle pulse on terminal count
//   active     registered channel-running flag
module timer_bank #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 11,
  parameter int unsigned PRESCALE = 1,
  localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [CW-1:0]       wr_chan,
  input  logic [WIDTH-1:0]    wr_period,
  input  logic                wr_oneshot,
  input  logic                wr_start,
  input  logic [CHANNELS-1:0] en,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] active
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]    pre;
  logic             step;
  logic             wr_valid;
  logic [WIDTH-1:0] period_q [CHANNELS];
  logic [WIDTH-1:0] cnt      [CHANNELS];
  logic [CHANNELS-1:0] oneshot_q;

  assign step     = (pre == PW'(PRESCALE - 1));
  assign wr_valid = wr_en && (32'(wr_chan) < CHANNELS);

  // Shared prescaler, free-running regardless of channel enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
    end else if (step) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  // Per-channel counters. A write to a channel takes priority over its step,
  // so a step coinciding with a write is dropped (and cannot tick).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        period_q[c] <= '0;
        cnt[c]      <= '0;
      end
      oneshot_q <= '0;
      active    <= '0;
      tick      <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        tick[c] <= 1'b0;
        if (wr_valid && (wr_chan == CW'(c))) begin
          period_q[c]  <= wr_period;
          oneshot_q[c] <= wr_oneshot;
          if (wr_start) begin
            cnt[c]    <= wr_period;
            active[c] <= 1'b1;
          end
        end else if (step && active[c] && en[c]) begin
          if (cnt[c] == WIDTH'(1)) begin
            tick[c] <= 1'b1;
            if (oneshot_q[c]) begin
              cnt[c]    <= '0;
              active[c] <= 1'b0;
            end else begin
              cnt[c] <= period_q[c];
            end
          end else begin
            // 0 wraps to all-ones, giving the 2^WIDTH interval for period 0.
            cnt[c] <= cnt[c] - WIDTH'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: drives two timer_bank instances from shared write inputs.
//   dut_a: 4 channels, WIDTH=4,  PRESCALE=1
//   dut_b: 3 channels, WIDTH=11, PRESCALE=4 (wr_chan=3 is out of range here)
// A reference model tracks steps-remaining-until-tick per channel.
module tb_timer_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_chan;
  logic [10:0] wr_period;
  logic        wr_oneshot;
  logic        wr_start;
  logic [3:0]  en_a;
  logic [2:0]  en_b;
  logic [3:0]  tick_a, active_a;
  logic [2:0]  tick_b, active_b;
  logic [15:0] got_all;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  timer_bank #(.CHANNELS(4), .WIDTH(4), .PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_chan(wr_chan),
    .wr_period(wr_period[3:0]), .wr_oneshot(wr_oneshot), .wr_start(wr_start),
    .en(en_a), .tick(tick_a), .active(active_a)
  );

  timer_bank #(.CHANNELS(3), .WIDTH(11), .PRESCALE(4)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_chan(wr_chan),
    .wr_period(wr_period), .wr_oneshot(wr_oneshot), .wr_start(wr_start),
    .en(en_b), .tick(tick_b), .active(active_b)
  );

  assign got_all = {tick_a, active_a, 1'b0, tick_b, 1'b0, active_b};

  // Reference model: rem = steps still needed before the next tick.
  int m_pre [2];
  int m_per [2][4];
  int m_rem [2][4];
  bit m_os  [2][4];
  bit m_act [2][4];
  bit m_tk  [2][4];

  function automatic int nch(int i); return (i == 0) ? 4 : 3; endfunction
  function automatic int wid(int i); return (i == 0) ? 4 : 11; endfunction
  function automatic int psc(int i); return (i == 0) ? 1 : 4; endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int full;
      int wp;
      bit step;
      bit en_c;
      full = 1 << wid(i);
      if (rst) begin
        m_pre[i] = 0;
        for (int c = 0; c < 4; c++) begin
          m_per[i][c] = 0; m_rem[i][c] = full;
          m_os[i][c] = 0; m_act[i][c] = 0; m_tk[i][c] = 0;
        end
        continue;
      end
      step = (m_pre[i] == psc(i) - 1);
      m_pre[i] = (m_pre[i] + 1) % psc(i);
      wp = int'(wr_period) % full;
      for (int c = 0; c < nch(i); c++) begin
        if (i == 0) en_c = en_a[c]; else en_c = en_b[c];
        m_tk[i][c] = 0;
        if (wr_en && int'(wr_chan) == c) begin
          m_per[i][c] = wp;
          m_os[i][c]  = wr_oneshot;
          if (wr_start) begin
            m_rem[i][c] = (wp == 0) ? full : wp;
            m_act[i][c] = 1;
          end
        end else if (step && m_act[i][c] && en_c) begin
          if (m_rem[i][c] == 1) begin
            m_tk[i][c] = 1;
            if (m_os[i][c]) m_act[i][c] = 0;
            else m_rem[i][c] = (m_per[i][c] == 0) ? full : m_per[i][c];
          end else begin
            m_rem[i][c] = m_rem[i][c] - 1;
          end
        end
      end
    end
  endtask

  function automatic logic [15:0] exp_all();
    logic [3:0] ta, aa, tb, ab;
    ta = '0; aa = '0; tb = '0; ab = '0;
    for (int c = 0; c < 4; c++) begin ta[c] = m_tk[0][c]; aa[c] = m_act[0][c]; end
    for (int c = 0; c < 3; c++) begin tb[c] = m_tk[1][c]; ab[c] = m_act[1][c]; end
    return {ta, aa, tb, ab};
  endfunction

  // One clock edge: model advances with the DUT, outputs sampled 1ns later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en = 0; wr_chan = 0; wr_period = 0; wr_oneshot = 0; wr_start = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle(); en_a = '1; en_b = '1;
    cyc();
    rst = 0;
  endtask

  task automatic write(input int ch, input int per, input bit os, input bit st);
    wr_en = 1; wr_chan = 2'(ch); wr_period = 11'(per); wr_oneshot = os; wr_start = st;
  endtask

  task automatic test_reset();
    rst = 1;
    for (int k = 0; k < 3; k++) begin
      wr_en = 1'($urandom); wr_chan = 2'($urandom); wr_period = 11'($urandom);
      wr_oneshot = 1'($urandom); wr_start = 1'($urandom);
      en_a = 4'($urandom); en_b = 3'($urandom);
      cyc();
      tests++;
      if ({tick_a, active_a, tick_b, active_b} !== 14'd0) begin
        fails++;
        $display("FAIL reset_hold k=%0d got=%h exp=0", k, {tick_a, active_a, tick_b, active_b});
      end
    end
    rst = 0; idle(); en_a = '1; en_b = '1;
    write(0, 3, 0, 1);
    cyc();
    idle();
    tests++;
    if (active_a[0] !== 1'b1 || active_b[0] !== 1'b1) begin
      fails++;
      $display("FAIL reset_first_write got=%b/%b exp=1/1", active_a[0], active_b[0]);
    end
    tests++;
    if (got_all !== exp_all()) begin
      fails++;
      $display("FAIL reset_model got=%h exp=%h", got_all, exp_all());
    end
  endtask

  task automatic test_periodic();
    do_reset();
    write(0, 3, 0, 1);
    cyc();
    idle();
    for (int k = 1; k <= 10; k++) begin
      cyc();
      tests++;
      if (tick_a[0] !== 1'(k % 3 == 0) || active_a[0] !== 1'b1) begin
        fails++;
        $display("FAIL periodic k=%0d got tick=%b act=%b exp tick=%b act=1",
                 k, tick_a[0], active_a[0], 1'(k % 3 == 0));
      end
      tests++;
      if (got_all !== exp_all()) begin
        fails++;
        $display("FAIL periodic_model k=%0d got=%h exp=%h", k, got_all, exp_all());
      end
    end
  endtask

  task automatic test_oneshot();
    int n;
    int at;
    n = 0; at = -1;
    do_reset();
    write(1, 2, 1, 1);
    cyc();
    idle();
    for (int k = 1; k <= 30; k++) begin
      cyc();
      if (k == 6) begin
        tests++;
        if (active_b[1] !== 1'b1) begin
          fails++;
          $display("FAIL oneshot_active_before got=%b exp=1", active_b[1]);
        end
      end
      if (tick_b[1]) begin
        n++; at = k;
        tests++;
        if (active_b[1] !== 1'b0) begin
          fails++;
          $display("FAIL oneshot_active_fall k=%0d got=%b exp=0", k, active_b[1]);
        end
      end
      tests++;
      if (got_all !== exp_all()) begin
        fails++;
        $display("FAIL oneshot_model k=%0d got=%h exp=%h", k, got_all, exp_all());
      end
    end
    // Write edge leaves pre=1; steps fall on edges 3 and 7 after it.
    tests++;
    if (n !== 1 || at !== 7) begin
      fails++;
      $display("FAIL oneshot_ticks got n=%0d at=%0d exp n=1 at=7", n, at);
    end
  endtask

  task automatic test_wrap();
    int tq[$];
    do_reset();
    write(2, 0, 0, 1);
    cyc();
    idle();
    for (int k = 1; k <= 60; k++) begin
      if (k == 41) write(2, 5, 0, 0);
      cyc();
      if (k == 41) idle();
      if (tick_a[2]) tq.push_back(k);
      tests++;
      if (got_all !== exp_all()) begin
        fails++;
        $display("FAIL wrap_model k=%0d got=%h exp=%h", k, got_all, exp_all());
      end
    end
    // The reconfiguring write on edge 41 costs one step, so the interval
    // in flight ends at 49 instead of 48; the following one is 5 steps.
    tests++;
    if (tq.size() < 4) begin
      fails++;
      $display("FAIL wrap_count got=%0d exp>=4", tq.size());
    end else if (tq[0] != 16 || tq[1] != 32 || tq[2] != 49 || tq[3] != 54) begin
      fails++;
      $display("FAIL wrap_times got=%0d,%0d,%0d,%0d exp=16,32,49,54", tq[0], tq[1], tq[2], tq[3]);
    end
  endtask

  task automatic test_enable();
    do_reset();
    write(0, 4, 0, 1);
    cyc();
    idle();
    for (int k = 1; k <= 28; k++) begin
      if (k == 7) en_a[0] = 0;
      if (k == 17) en_a[0] = 1;
      if (k == 22) write(0, 4, 0, 1);
      cyc();
      if (k == 22) idle();
      tests++;
      if (tick_a[0] !== 1'(k == 4 || k == 18 || k == 26)) begin
        fails++;
        $display("FAIL enable_tick k=%0d got=%b exp=%b", k, tick_a[0], 1'(k == 4 || k == 18 || k == 26));
      end
      tests++;
      if (got_all !== exp_all()) begin
        fails++;
        $display("FAIL enable_model k=%0d got=%h exp=%h", k, got_all, exp_all());
      end
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      write(c, 1, 0, 1);
      cyc();
    end
    idle();
    cyc();
    tests++;
    if (tick_a !== 4'hF) begin
      fails++;
      $display("FAIL midrun_ticking got=%h exp=f", tick_a);
    end
    rst = 1;
    cyc();
    rst = 0;
    tests++;
    if ({tick_a, active_a, tick_b, active_b} !== 14'd0) begin
      fails++;
      $display("FAIL midrun_reset got=%h exp=0", {tick_a, active_a, tick_b, active_b});
    end
    write(3, 2, 0, 1);
    cyc();
    idle();
    for (int k = 0; k < 12; k++) begin
      tests++;
      if (tick_b !== 3'b000 || active_b !== 3'b000 || active_a !== 4'b1000) begin
        fails++;
        $display("FAIL oob_write k=%0d got tb=%b ab=%b aa=%b exp 000/000/1000",
                 k, tick_b, active_b, active_a);
      end
      tests++;
      if (got_all !== exp_all()) begin
        fails++;
        $display("FAIL oob_model k=%0d got=%h exp=%h", k, got_all, exp_all());
      end
      cyc();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rst        = ($urandom % 200) == 0;
      wr_en      = ($urandom % 6) == 0;
      wr_chan    = 2'($urandom);
      wr_period  = (($urandom % 5) == 0) ? 11'($urandom) : 11'($urandom_range(0, 6));
      wr_oneshot = 1'($urandom);
      wr_start   = ($urandom % 4) != 0;
      for (int c = 0; c < 4; c++) en_a[c] = ($urandom % 8) != 0;
      for (int c = 0; c < 3; c++) en_b[c] = ($urandom % 8) != 0;
      cyc();
      tests++;
      if (got_all !== exp_all()) begin
        fails++;
        $display("FAIL random_model k=%0d got=%h exp=%h", k, got_all, exp_all());
      end
    end
    rst = 0;
    idle();
  endtask

  initial begin
    rst = 1; idle(); en_a = '1; en_b = '1;
    test_reset();
    test_periodic();
    test_oneshot();
    test_wrap();
    test_enable();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
